mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port data/instruction memory between two requesters: instruction fetch (IF, read-only) and
//  the load/store unit (D, read/write). Each requester uses a req/ack handshake; the arbiter picks one, runs one
//  memory access (optionally stretched by wait cycles), returns read data and pulses ack. Sits between the core
//  pipeline and the memory (Address/In/MemWr/MemRd/Out; write on posedge clk, combinational read while MemRd).
// PARAMETERS
//  AW          32    address width of requester and memory ports
//  DW          32    data width
//  DEPTH       4096  number of memory words; addresses >= DEPTH are out of range
//  WAIT_CYCLES 0     extra cycles an access is held on the memory bus before completion (0..15)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  if_req     in   1   IF read request; held with if_addr stable until if_ack
//  if_addr    in   AW  IF word address
//  if_ack     out  1   one-cycle completion pulse for IF
//  if_rdata   out  DW  IF read data, valid while if_ack=1, held until next IF completion
//  d_req      in   1   data request; held with d_we/d_addr/d_wdata stable until d_ack
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   AW  data word address
//  d_wdata    in   DW  store data
//  d_ack      out  1   one-cycle completion pulse for D
//  d_rdata    out  DW  load data, valid while d_ack=1 (0 for stores), held until next D completion
//  err        out  1   with ack: access was out of range and not performed
//  busy       out  1   1 when state != IDLE
//  mem_addr   out  AW  to memory Address
//  mem_wdata  out  DW  to memory In
//  mem_wr     out  1   to memory MemWr
//  mem_rd     out  1   to memory MemRd
//  mem_rdata  in   DW  from memory Out
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all outputs 0, wait counter 0, round-robin pointer favours IF.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: if any req, choose winner, latch its addr/we/wdata and id, load cnt=WAIT_CYCLES, go ACCESS.
//         If winner address >= DEPTH: go straight to DONE with err pending; no memory strobe issued.
//   ACCESS: mem_addr/mem_wdata = latched values; mem_rd=1 every ACCESS cycle of a load;
//         mem_wr=1 only in final ACCESS cycle (cnt==0) of a store -> exactly one write per store.
//         cnt!=0: decrement. cnt==0: register mem_rdata (loads) into winner's rdata, go DONE.
//   DONE: winner's ack=1 for exactly this cycle, err valid; update round-robin pointer; go IDLE.
//  Latency: req sampled in IDLE -> ack in cycle IDLE+WAIT_CYCLES+2; throughput one access per WAIT_CYCLES+3 cycles.
//  Arbitration: only one req -> it wins. Both -> winner is the one NOT granted last (round robin);
//   after reset IF wins the first tie. No requester waits more than one other access.
//  Handshake: requester drops or replaces req at the edge ending its ack cycle; req is not sampled in ACCESS/DONE,
//   so a req that rises mid-access is served from the next IDLE. Dropping req before ack is illegal (assertion).
//  if_ack and d_ack never both 1; mem_wr and mem_rd never both 1; mem_* = 0 outside ACCESS.
//  rdata registers change only on their own requester's completion; store completes with d_rdata=0.
//  Reset mid-access: everything returns to reset values immediately; no ack issued; an in-flight store whose final
//   cycle had not reached the clock edge is not written; requesters still holding req are re-arbitrated after reset.
// STRUCTURE
//  Package mem_arb_pkg: state encoding (IDLE/ACCESS/DONE), requester id constants (ID_IF=0, ID_D=1),
//   WAIT counter width (4 bits).
//  Sub-module rr_pick2: 2-way round-robin selector (req[1:0], last_id -> grant id, valid); pure logic plus pointer reg.
//  Top holds FSM, latched request fields, wait counter, output data registers.
// TESTING
//  1 Single IF read, WAIT_CYCLES=0, mem[0x10]=0xDEADBEEF: if_req addr 0x10 -> if_ack on cycle 3, if_rdata=0xDEADBEEF, err=0.
//  2 Store then load: d_we=1 addr 0x20 data 0x12345678 -> one mem_wr pulse, d_ack; load addr 0x20 -> d_rdata=0x12345678.
//  3 Both req held continuously from reset -> grants IF,D,IF,D...; no ack gap longer than 6 cycles (WAIT_CYCLES=0).
//  4 WAIT_CYCLES=3 store addr 0x5: mem_wr high exactly 1 cycle (last of 4 ACCESS cycles); d_ack 5 cycles after IDLE sample.
//  5 d_addr=4096 load -> d_ack with err=1, d_rdata=0, mem_rd/mem_wr never asserted.
//  6 rst_n low during ACCESS of store to 0x30 (WAIT_CYCLES=2, before final cycle) -> no ack, mem[0x30] unchanged,
//    all outputs 0; after release, held d_req re-served and acked.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and constants for the memory arbiter
// Rev 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic ID_IF  = 1'b0;
  localparam logic ID_D   = 1'b1;
  localparam int   WAIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : 2-way round-robin selector; req[0]=IF, req[1]=D
// Rev 1.0
// ============================================================================
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       gnt_id,
  output logic       valid
);

  logic r_last;

  // Resetting to D makes IF the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= ID_D;
    end else if (upd) begin
      r_last <= upd_id;
    end
  end

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      gnt_id = ~r_last;
    end else begin
      gnt_id = req[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one single-port memory between IF and D requesters
// Rev 1.0
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0]     c_depth = AW'(DEPTH);
  localparam logic [WAIT_W-1:0] c_wait  = WAIT_W'(WAIT_CYCLES);

  state_t            r_state;
  logic              r_id;
  logic              r_we;
  logic [WAIT_W-1:0] r_cnt;

  logic              w_gnt_id;
  logic              w_valid;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_wdata;
  logic              w_we;
  logic              w_oor;

  rr_pick2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({d_req, if_req}),
    .upd    (r_state == DONE),
    .upd_id (r_id),
    .gnt_id (w_gnt_id),
    .valid  (w_valid)
  );

  always_comb begin
    w_addr  = w_gnt_id ? d_addr : if_addr;
    w_wdata = w_gnt_id ? d_wdata : '0;
    w_we    = w_gnt_id & d_we;
    w_oor   = (w_addr >= c_depth);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_id      <= ID_IF;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_id  <= w_gnt_id;
            r_we  <= w_we;
            r_cnt <= c_wait;
            busy  <= 1'b1;
            if (w_oor) begin
              // Out-of-range: complete immediately without touching memory.
              r_state <= DONE;
              err     <= 1'b1;
              if (w_gnt_id == ID_D) begin
                d_ack   <= 1'b1;
                d_rdata <= '0;
              end else begin
                if_ack   <= 1'b1;
                if_rdata <= '0;
              end
            end else begin
              r_state   <= ACCESS;
              mem_addr  <= w_addr;
              mem_wdata <= w_wdata;
              mem_rd    <= ~w_we;
              mem_wr    <= w_we && (c_wait == '0);
            end
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - WAIT_W'(1);
            mem_wr <= r_we && (r_cnt == WAIT_W'(1));
          end else begin
            r_state   <= DONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            if (r_id == ID_D) begin
              d_ack   <= 1'b1;
              d_rdata <= r_we ? '0 : mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // The granted requester must keep its request up for the whole access.
  ap_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ACCESS) |-> ((r_id == ID_D) ? d_req : if_req));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : self-checking bench, three arbiters with WAIT_CYCLES 0/2/3
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        load_mem;
  logic        if_req   [3];
  logic [31:0] if_addr  [3];
  logic        if_ack   [3];
  logic [31:0] if_rdata [3];
  logic        d_req    [3];
  logic        d_we     [3];
  logic [31:0] d_addr   [3];
  logic [31:0] d_wdata  [3];
  logic        d_ack    [3];
  logic [31:0] d_rdata  [3];
  logic        err      [3];
  logic        busy     [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata[3];
  logic        mem_wr   [3];
  logic        mem_rd   [3];
  logic [31:0] mem_rdata[3];

  logic [31:0] mem [3][4096];
  logic [31:0] mdl [3][4096];

  int nchk = 0;
  int nfail = 0;
  int viol = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(
      .AW(32), .DW(32), .DEPTH(4096),
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]), .err(err[g]), .busy(busy[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wr(mem_wr[g]),
      .mem_rd(mem_rd[g]), .mem_rdata(mem_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int k, input int i);
    case (i)
      'h10:    return 32'hDEADBEEF;
      'h30:    return 32'hA5A5A5A5;
      4095:    return 32'h0F0F1234;
      default: return (32'(i) * 32'h01000193) ^ 32'(k << 24);
    endcase
  endfunction

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  // Memory: synchronous write, combinational read while mem_rd.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 4096; i++) mem[k][i] <= pat(k, i);
    end else begin
      for (int k = 0; k < 3; k++)
        if (mem_wr[k]) mem[k][mem_addr[k][11:0]] <= mem_wdata[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++)
      mem_rdata[k] = mem_rd[k] ? mem[k][mem_addr[k][11:0]] : 32'h0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if ((if_ack[k] && d_ack[k]) || (mem_wr[k] && mem_rd[k])) viol++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input int k, input bit is_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata_e, input bit err_e,
                           input int lat_e, input int wr_e, input int rd_e);
    int n, nwr, nrd, wr_at, stray;
    bit got;
    logic [31:0] other_before, rd_act;
    logic err_act;
    other_before = is_d ? if_rdata[k] : d_rdata[k];
    if (is_d) begin
      d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata; d_req[k] = 1'b1;
    end else begin
      if_addr[k] = addr; if_req[k] = 1'b1;
    end
    n = 0; nwr = 0; nrd = 0; wr_at = -1; stray = 0; got = 0;
    rd_act = 'x; err_act = 1'bx;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (mem_wr[k]) begin nwr++; wr_at = n; end
      if (mem_rd[k]) nrd++;
      if (is_d ? if_ack[k] : d_ack[k]) stray++;
      if (is_d ? d_ack[k] : if_ack[k]) begin
        got = 1;
        rd_act = is_d ? d_rdata[k] : if_rdata[k];
        err_act = err[k];
      end
    end
    if (is_d) d_req[k] = 1'b0; else if_req[k] = 1'b0;
    check("ack_seen", 64'(got), 64'd1);
    check("ack_latency", 64'(n), 64'(lat_e));
    check("rdata", 64'(rd_act), 64'(rdata_e));
    check("err", 64'(err_act), 64'(err_e));
    check("mem_wr_cycles", 64'(nwr), 64'(wr_e));
    check("mem_rd_cycles", 64'(nrd), 64'(rd_e));
    check("mem_wr_position", 64'(wr_at), wr_e != 0 ? 64'(lat_e - 1) : 64'(-1));
    check("other_ack_silent", 64'(stray), 64'd0);
    check("other_rdata_held", 64'(is_d ? if_rdata[k] : d_rdata[k]), 64'(other_before));
    if (wr_e != 0) begin
      mdl[k][addr[11:0]] = wdata;
      check("mem_written", 64'(mem[k][addr[11:0]]), 64'(wdata));
    end
    @(posedge clk); #1;
    check("idle_after_done", 64'({busy[k], if_ack[k], d_ack[k], err[k]}), 64'd0);
  endtask

  typedef struct {
    int          k;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          wr;
    int          rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n, acks, last_n;
    bit is_d, we, oor;
    logic [31:0] addr, wdata;
    int w;

    vecs[0] = '{0, 0, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 0, 1};
    vecs[1] = '{0, 1, 1, 32'h20,       32'h12345678, 32'h0,        0, 2, 1, 0};
    vecs[2] = '{0, 1, 0, 32'h20,       32'h0,        32'h12345678, 0, 2, 0, 1};
    vecs[3] = '{0, 1, 0, 32'd4096,     32'h0,        32'h0,        1, 1, 0, 0};
    vecs[4] = '{0, 0, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 1, 0, 0};
    vecs[5] = '{0, 1, 0, 32'd4095,     32'h0,        32'h0F0F1234, 0, 2, 0, 1};
    vecs[6] = '{2, 1, 1, 32'h5,        32'hCAFEF00D, 32'h0,        0, 5, 1, 0};
    vecs[7] = '{2, 0, 0, 32'h5,        32'h0,        32'hCAFEF00D, 0, 5, 0, 4};
    vecs[8] = '{1, 0, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 4, 0, 3};
    vecs[9] = '{2, 1, 1, 32'd4096,     32'h55,       32'h0,        1, 1, 0, 0};

    for (int k = 0; k < 3; k++) begin
      if_req[k] = 0; if_addr[k] = 0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
      for (int i = 0; i < 4096; i++) mdl[k][i] = pat(k, i);
    end
    rst_n = 1'b0;
    load_mem = 1'b1;
    @(posedge clk); #1;
    load_mem = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      check("reset_ctrl", 64'({if_ack[k], d_ack[k], err[k], busy[k], mem_wr[k], mem_rd[k]}), 64'd0);
      check("reset_mem_bus", {mem_addr[k], mem_wdata[k]}, 64'd0);
      check("reset_rdata", {if_rdata[k], d_rdata[k]}, 64'd0);
    end

    // Both requesters held from reset on the zero-wait arbiter.
    if_addr[0] = 32'h10; if_req[0] = 1'b1;
    d_addr[0] = 32'h30; d_we[0] = 1'b0; d_req[0] = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    n = 0; acks = 0; last_n = 0;
    while (acks < 8 && n < 60) begin
      @(posedge clk); #1; n++;
      if (if_ack[0] || d_ack[0]) begin
        check("rr_order", 64'(d_ack[0]), 64'(acks % 2));
        check("rr_rdata", 64'(d_ack[0] ? d_rdata[0] : if_rdata[0]),
              d_ack[0] ? 64'h A5A5A5A5 : 64'hDEADBEEF);
        check("rr_gap", 64'((n - last_n) <= 6), 64'd1);
        last_n = n;
        acks++;
        if (acks == 8) begin if_req[0] = 1'b0; d_req[0] = 1'b0; end
      end
    end
    check("rr_ack_count", 64'(acks), 64'd8);
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a store on the WAIT_CYCLES=2 arbiter.
    d_we[1] = 1'b1; d_addr[1] = 32'h30; d_wdata[1] = 32'h0BADCAFE; d_req[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midreset_busy_before", 64'(busy[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", 64'({d_ack[1], if_ack[1], err[1], busy[1], mem_wr[1], mem_rd[1]}), 64'd0);
    check("midreset_bus", {mem_addr[1], mem_wdata[1]}, 64'd0);
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (d_ack[1]) acks++;
    end
    check("midreset_no_ack", 64'(acks), 64'd0);
    check("midreset_mem_kept", 64'(mem[1][12'h30]), 64'hA5A5A5A5);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (!d_ack[1] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("reserve_latency", 64'(n), 64'd4);
    check("reserve_rdata", 64'(d_rdata[1]), 64'd0);
    d_req[1] = 1'b0;
    @(posedge clk); #1;
    check("reserve_mem_written", 64'(mem[1][12'h30]), 64'h0BADCAFE);
    mdl[1][12'h30] = 32'h0BADCAFE;

    for (int v = 0; v < 10; v++) begin
      do_access(vecs[v].k, vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                vecs[v].rdata, vecs[v].err, vecs[v].lat, vecs[v].wr, vecs[v].rd);
    end

    // Random accesses against the memory model.
    for (int k = 0; k < 3; k++) begin
      w = wait_of(k);
      for (int i = 0; i < 30; i++) begin
        is_d = 1'($urandom % 2);
        we = is_d & 1'($urandom % 2);
        addr = ($urandom % 16 == 0) ? 32'(4096 + $urandom % 100) : 32'($urandom % 32);
        wdata = $urandom;
        oor = (addr >= 32'd4096);
        do_access(k, is_d, we, addr, wdata,
                  (oor || we) ? 32'h0 : mdl[k][addr[11:0]], oor,
                  oor ? 1 : w + 2,
                  (!oor && we) ? 1 : 0,
                  (!oor && !we) ? w + 1 : 0);
      end
    end

    check("exclusive_ack_and_strobe", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
